vec_fb_writer: RTL and testbench

//  Write side of the VGA framebuffer; the VGA controller reads the same buffer.

---
 rtl/vec_fb_writer.sv | 133 +++++++++++++
 tb/tb_vec_fb_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_fb_writer.sv
// Vector store writer for the VGA framebuffer: serializes one 8-lane x 32-bit
// store into single-word RAM writes at base+lane, skipping masked/out-of-range lanes.
//
//   state  | meaning
//   IDLE   | ready for a request; zero-effective-mask requests complete here
//   RUN    | presenting pending lanes, lowest first, one word per grant
module vec_fb_writer #(
    parameter int LANES    = 8,
    parameter int ADDR_W   = 16,
    parameter int FB_DEPTH = 40000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [32*LANES-1:0]   i_req_data,
    input  logic [LANES-1:0]      i_req_mask,
    output logic                  o_fb_we,
    input  logic                  i_fb_gnt,
    output logic [ADDR_W-1:0]     o_fb_addr,
    output logic [31:0]           o_fb_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [7:0]            o_oob_count
);
    localparam int LW = $clog2(LANES);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_base;
    logic [32*LANES-1:0]   r_data;
    logic [LANES-1:0]      r_mask;
    logic [LW-1:0]         r_lane;
    logic                  r_fb_we;
    logic [ADDR_W-1:0]     r_fb_addr;
    logic [31:0]           r_fb_wdata;
    logic                  r_done;
    logic [7:0]            r_oob;

    logic [LANES-1:0]      w_eff;
    logic [LW:0]           w_drop_cnt;
    logic                  w_grant;
    logic [LANES-1:0]      w_left;
    logic                  w_last;
    logic                  w_accept;
    logic [LANES-1:0]      w_mask_nxt;
    logic [ADDR_W-1:0]     w_base_nxt;
    logic [32*LANES-1:0]   w_data_nxt;
    logic [LW-1:0]         w_lane_nxt;
    logic                  w_done_nxt;
    logic [8:0]            w_oob_sum;
    logic [ADDR_W:0]       w_sum;

    // One extra address bit so a lane wrapping past the top of the space is out of bounds.
    always_comb begin
        w_eff      = '0;
        w_drop_cnt = '0;
        w_sum      = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum    = {1'b0, i_req_addr} + (ADDR_W+1)'(i);
            w_eff[i] = i_req_mask[i] && (w_sum < (ADDR_W+1)'(FB_DEPTH));
            if (i_req_mask[i] && !w_eff[i])
                w_drop_cnt = w_drop_cnt + 1'b1;
        end
    end

    always_comb begin
        w_grant     = r_fb_we && i_fb_gnt;
        w_left      = r_mask & ~(LANES'(1) << r_lane);
        w_last      = (r_state == S_RUN) && w_grant && (w_left == '0);
        o_req_ready = (r_state == S_IDLE) || w_last;
        w_accept    = i_req_valid && o_req_ready;

        w_mask_nxt = r_mask;
        if ((r_state == S_RUN) && w_grant)
            w_mask_nxt = w_left;
        if (w_accept)
            w_mask_nxt = w_eff;

        w_base_nxt = w_accept ? i_req_addr : r_base;
        w_data_nxt = w_accept ? i_req_data : r_data;

        w_lane_nxt = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_mask_nxt[i])
                w_lane_nxt = LW'(i);
        end

        w_state_nxt = (w_mask_nxt != '0) ? S_RUN : S_IDLE;
        w_done_nxt  = (w_accept && (w_eff == '0)) || w_last;
        w_oob_sum   = {1'b0, r_oob} + 9'(w_drop_cnt);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_data     <= '0;
            r_mask     <= '0;
            r_lane     <= '0;
            r_fb_we    <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_wdata <= '0;
            r_done     <= 1'b0;
            r_oob      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_data  <= w_data_nxt;
            r_mask  <= w_mask_nxt;
            r_lane  <= w_lane_nxt;
            r_fb_we <= (w_mask_nxt != '0);
            r_done  <= w_done_nxt;
            if (w_mask_nxt != '0) begin
                r_fb_addr  <= w_base_nxt + ADDR_W'(w_lane_nxt);
                r_fb_wdata <= w_data_nxt[32*w_lane_nxt +: 32];
            end
            if (w_accept)
                r_oob <= w_oob_sum[8] ? 8'hFF : w_oob_sum[7:0];
        end
    end

    assign o_fb_we     = r_fb_we;
    assign o_fb_addr   = r_fb_addr;
    assign o_fb_wdata  = r_fb_wdata;
    assign o_busy      = (r_state == S_RUN);
    assign o_done      = r_done;
    assign o_oob_count = r_oob;

endmodule

// File: tb/tb_vec_fb_writer.sv
// Bench for vec_fb_writer: scenario tasks plus a scoreboard of expected
// (address, word) commits popped whenever the RAM port grants a write.
module tb_vec_fb_writer;
    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [15:0]   req_addr;
    logic [255:0]  req_data;
    logic [7:0]    req_mask;
    logic          fb_we;
    logic          fb_gnt;
    logic [15:0]   fb_addr;
    logic [31:0]   fb_wdata;
    logic          busy;
    logic          done;
    logic [7:0]    oob_count;

    int checks = 0;
    int errors = 0;
    int exp_oob = 0;
    logic [47:0] sb[$];

    vec_fb_writer dut (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_data(req_data), .i_req_mask(req_mask),
        .o_fb_we(fb_we), .i_fb_gnt(fb_gnt), .o_fb_addr(fb_addr), .o_fb_wdata(fb_wdata),
        .o_busy(busy), .o_done(done), .o_oob_count(oob_count)
    );

    always #5 clk = ~clk;

    // Every granted write must match the oldest outstanding expected commit.
    always @(negedge clk) begin
        if (!reset && fb_we && fb_gnt) begin
            logic [47:0] e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got addr=%h data=%h, expected no write", fb_addr, fb_wdata);
            end else begin
                e = sb.pop_front();
                if ({fb_addr, fb_wdata} !== e) begin
                    errors++;
                    $display("FAIL commit: got addr=%h data=%h, expected addr=%h data=%h",
                             fb_addr, fb_wdata, e[47:32], e[31:0]);
                end
            end
        end
    end

    function automatic logic [255:0] make_data(input logic [31:0] seed);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = seed + 32'(i);
        return d;
    endfunction

    // Waits for ready, presents the request for exactly the accept cycle, then
    // scrambles the inputs. Returns at posedge+1 of the cycle after accept.
    task automatic issue(input logic [15:0] a, input logic [255:0] d, input logic [7:0] m);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got req_ready=0, expected 1 within 200 cycles");
        end
        req_valid = 1'b1; req_addr = a; req_data = d; req_mask = m;
        for (int i = 0; i < 8; i++) begin
            int s = int'(a) + i;
            if (m[i] && s < 40000) sb.push_back({16'(s), d[32*i +: 32]});
            else if (m[i]) exp_oob = (exp_oob < 255) ? exp_oob + 1 : 255;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_data = ~d; req_mask = ~m; req_addr = a ^ 16'h5A5A;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got done=0, expected pulse within 200 cycles");
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL writes_missing: got %0d outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_mask = '0; fb_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, fb_we, fb_addr, fb_wdata, busy, done, oob_count} !== {1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 8'h0}) begin
            errors++;
            $display("FAIL reset_values: got ready=%b we=%b addr=%h wdata=%h busy=%b done=%b oob=%0d, expected 1 0 0000 00000000 0 0 0",
                     req_ready, fb_we, fb_addr, fb_wdata, busy, done, oob_count);
        end
    endtask

    task automatic test_full_mask();
        fb_gnt = 1'b1;
        issue(16'h0100, make_data(32'h00A0_0000), 8'hFF);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (fb_we !== 1'b1 || busy !== 1'b1 || fb_addr !== 16'h0100 + 16'(k-1)) begin
                errors++;
                $display("FAIL full_cycle%0d: got we=%b busy=%b addr=%h, expected 1 1 %h", k, fb_we, busy, fb_addr, 16'h0100 + 16'(k-1));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || fb_we !== 1'b0) begin
            errors++;
            $display("FAIL full_done_cycle9: got done=%b we=%b, expected 1 0", done, fb_we);
        end
    endtask

    task automatic test_sparse();
        fb_gnt = 1'b1;
        issue(16'h0010, make_data(32'h1111_0000), 8'h81);
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 16'h0010) begin
            errors++; $display("FAIL sparse_first: got we=%b addr=%h, expected 1 0010", fb_we, fb_addr);
        end
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 16'h0017) begin
            errors++; $display("FAIL sparse_second: got we=%b addr=%h, expected 1 0017", fb_we, fb_addr);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || fb_we !== 1'b0) begin
            errors++; $display("FAIL sparse_done: got done=%b we=%b, expected 1 0", done, fb_we);
        end
    endtask

    task automatic test_stall();
        fb_gnt = 1'b0;
        issue(16'h0200, make_data(32'h2222_0000), 8'h03);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (fb_we !== 1'b1 || fb_addr !== 16'h0200 || fb_wdata !== 32'h2222_0000 || done !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got we=%b addr=%h data=%h done=%b, expected 1 0200 22220000 0", k, fb_we, fb_addr, fb_wdata, done);
            end
        end
        @(posedge clk); #1 fb_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 16'h0200) begin
            errors++; $display("FAIL stall_grant: got we=%b addr=%h, expected 1 0200", fb_we, fb_addr);
        end
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 16'h0201 || fb_wdata !== 32'h2222_0001) begin
            errors++; $display("FAIL stall_lane1: got we=%b addr=%h data=%h, expected 1 0201 22220001", fb_we, fb_addr, fb_wdata);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL stall_done: got done=%b, expected 1", done);
        end
    endtask

    task automatic test_bounds();
        fb_gnt = 1'b1;
        issue(16'd39996, make_data(32'h3333_0000), 8'hFF);
        wait_done();
        checks++;
        if (oob_count !== 8'(exp_oob)) begin
            errors++; $display("FAIL bounds_oob4: got %0d, expected %0d", oob_count, exp_oob);
        end
        issue(16'hFFFE, make_data(32'h4444_0000), 8'hFF);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || fb_we !== 1'b0 || busy !== 1'b0 || oob_count !== 8'(exp_oob)) begin
            errors++;
            $display("FAIL bounds_wrap: got done=%b we=%b busy=%b oob=%0d, expected 1 0 0 %0d", done, fb_we, busy, oob_count, exp_oob);
        end
        for (int r = 0; r < 31; r++) issue(16'hFFF8, make_data(32'h0), 8'hFF);
        @(negedge clk);
        checks++;
        if (oob_count !== 8'(exp_oob) || exp_oob != 255) begin
            errors++; $display("FAIL oob_saturate: got %0d, expected %0d", oob_count, exp_oob);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] db;
        fb_gnt = 1'b1;
        db = make_data(32'h5555_0000);
        issue(16'h0300, make_data(32'h6666_0000), 8'h03);
        req_valid = 1'b1; req_addr = 16'h0310; req_data = db; req_mask = 8'h05;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_not_ready: got ready=%b, expected 0", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || fb_we !== 1'b1 || fb_addr !== 16'h0301) begin
            errors++; $display("FAIL b2b_last_grant: got ready=%b we=%b addr=%h, expected 1 1 0301", req_ready, fb_we, fb_addr);
        end
        sb.push_back({16'h0310, db[31:0]});
        sb.push_back({16'h0312, db[95:64]});
        @(posedge clk); #1 req_valid = 1'b0; req_data = '0; req_mask = '0;
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 16'h0310 || done !== 1'b1) begin
            errors++; $display("FAIL b2b_no_gap: got we=%b addr=%h done=%b, expected 1 0310 1", fb_we, fb_addr, done);
        end
        wait_done();
    endtask

    task automatic test_reset_mid();
        fb_gnt = 1'b1;
        issue(16'h0400, make_data(32'h7777_0000), 8'hFF);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        exp_oob = 0;
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || oob_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_mid: got we=%b busy=%b ready=%b oob=%0d, expected 0 0 1 0", fb_we, busy, req_ready, oob_count);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (fb_we !== 1'b0) begin
                errors++; $display("FAIL reset_no_writes: got we=%b, expected 0", fb_we);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse();
        test_stall();
        test_bounds();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
